// File: rtl/nios2_ocimem_pkg.sv
// Shared types and JTAG data-out field positions for the OCI RAM arbiter.
package nios2_ocimem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    J_RD = 2'd1,
    A_RD = 2'd2
  } state_t;

  typedef enum logic {
    GNT_JTAG = 1'b0,
    GNT_AV   = 1'b1
  } grant_t;

  localparam int JDO_W         = 38;
  localparam int JDO_WR_BIT    = 35;
  localparam int JDO_WDATA_LSB = 3;
  localparam int JDO_ADDR_LSB  = 17;

endpackage

// File: rtl/nios2_ocimem_jtag_buf.sv
// JTAG side of the OCI RAM arbiter: address register with auto-increment,
// one-entry pending op buffer and sticky overrun flag.
module nios2_ocimem_jtag_buf
  import nios2_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_addr_load,
  input  logic              jtag_xfer,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              op_done,
  input  logic              in_flight,
  output logic              pend_valid,
  output logic              pend_wr,
  output logic [DATA_W-1:0] pend_wdata,
  output logic [ADDR_W-1:0] pend_addr,
  output logic              busy,
  output logic              overrun
);

  logic [ADDR_W-1:0] jtag_addr;
  logic [ADDR_W-1:0] jdo_addr;

  assign jdo_addr = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign busy     = pend_valid | in_flight;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jtag_addr  <= '0;
      pend_valid <= 1'b0;
      pend_wr    <= 1'b0;
      pend_wdata <= '0;
      pend_addr  <= '0;
      overrun    <= 1'b0;
    end else begin
      if (jtag_addr_load)
        jtag_addr <= jdo_addr;
      else if (op_done)
        jtag_addr <= jtag_addr + ADDR_W'(1);

      if (op_done)
        pend_valid <= 1'b0;

      // op_done implies busy, so a capture never collides with the clear above
      if (jtag_xfer) begin
        if (busy) begin
          overrun <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend_wr    <= jdo[JDO_WR_BIT];
          pend_wdata <= jdo[JDO_WDATA_LSB +: DATA_W];
          pend_addr  <= jtag_addr_load ? jdo_addr : jtag_addr;
        end
      end
    end
  end

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Shares the single-port OCI RAM between buffered JTAG debug ops and the
// Avalon debug_mem slave, round-robin on contention.
module nios2_ocimem_arbiter
  import nios2_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_addr_load,
  input  logic              jtag_xfer,
  input  logic [JDO_W-1:0]  jdo,
  output logic [DATA_W-1:0] mon_dreg,
  output logic              mon_ready,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_be,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t            state, state_nxt;
  grant_t            last_grant;
  logic              gnt_j, gnt_a, j_done, av_done, av_req;
  logic              pend_valid, pend_wr;
  logic [DATA_W-1:0] pend_wdata;
  logic [ADDR_W-1:0] pend_addr;

  nios2_ocimem_jtag_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_jtag_buf (
    .clk            (clk),
    .reset          (reset),
    .jtag_addr_load (jtag_addr_load),
    .jtag_xfer      (jtag_xfer),
    .jdo            (jdo),
    .op_done        (j_done),
    .in_flight      (state == J_RD),
    .pend_valid     (pend_valid),
    .pend_wr        (pend_wr),
    .pend_wdata     (pend_wdata),
    .pend_addr      (pend_addr),
    .busy           (jtag_busy),
    .overrun        (jtag_overrun)
  );

  assign av_req         = av_read | av_write;
  assign av_readdata    = ram_rdata;
  assign av_waitrequest = reset | (av_req & ~av_done);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GNT_JTAG;
      mon_dreg   <= '0;
      mon_ready  <= 1'b0;
    end else begin
      state     <= state_nxt;
      mon_ready <= j_done;
      if (state == J_RD)
        mon_dreg <= ram_rdata;
      if (gnt_j)
        last_grant <= GNT_JTAG;
      else if (gnt_a)
        last_grant <= GNT_AV;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_j     = 1'b0;
    gnt_a     = 1'b0;
    j_done    = 1'b0;
    av_done   = 1'b0;
    ram_addr  = pend_addr;
    ram_wdata = pend_wdata;
    ram_be    = 4'hF;
    ram_we    = 1'b0;
    case (state)
      IDLE: begin
        // grants are held off during reset so no write can slip out
        if (!reset) begin
          gnt_j = pend_valid & (~av_req | (last_grant == GNT_AV));
          gnt_a = av_req & ~gnt_j;
        end
        if (gnt_j) begin
          ram_we = pend_wr;
          if (pend_wr) j_done = 1'b1;
          else         state_nxt = J_RD;
        end
        if (gnt_a) begin
          ram_addr  = av_address;
          ram_wdata = av_writedata;
          ram_be    = av_byteenable;
          ram_we    = av_write;
          if (av_write) av_done = 1'b1;
          else          state_nxt = A_RD;
        end
      end
      J_RD: begin
        j_done    = 1'b1;
        state_nxt = IDLE;
      end
      A_RD: begin
        ram_addr  = av_address;
        av_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Directed bench for the OCI RAM arbiter with a behavioural 1-cycle-latency RAM.
module tb_nios2_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        jtag_addr_load, jtag_xfer;
  logic [37:0] jdo;
  logic [31:0] mon_dreg;
  logic        mon_ready, jtag_busy, jtag_overrun;
  logic [7:0]  av_address;
  logic        av_read, av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_we;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:255];
  int          we_cnt = 0;
  int          we_base;
  int          n_cmp = 0;
  int          n_err = 0;

  nios2_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .jtag_addr_load (jtag_addr_load),
    .jtag_xfer      (jtag_xfer),
    .jdo            (jdo),
    .mon_dreg       (mon_dreg),
    .mon_ready      (mon_ready),
    .jtag_busy      (jtag_busy),
    .jtag_overrun   (jtag_overrun),
    .av_address     (av_address),
    .av_read        (av_read),
    .av_write       (av_write),
    .av_writedata   (av_writedata),
    .av_byteenable  (av_byteenable),
    .av_readdata    (av_readdata),
    .av_waitrequest (av_waitrequest),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_be         (ram_be),
    .ram_we         (ram_we),
    .ram_rdata      (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
      we_cnt++;
    end
  end

  function automatic logic [37:0] jdo_addr(input logic [7:0] a);
    logic [37:0] v;
    v = '0;
    v[24:17] = a;
    return v;
  endfunction

  function automatic logic [37:0] jdo_xfer(input logic wr, input logic [31:0] wd);
    logic [37:0] v;
    v = '0;
    v[35] = wr;
    v[34:3] = wd;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    jtag_addr_load = 1'b0;
    jtag_xfer      = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h31] = 32'hCAFEF00D;
    mem[8'h32] = 32'h13579BDF;
    mem[8'h40] = 32'h0BADF00D;
    mem[8'h50] = 32'h600DCAFE;
    reset = 1'b1;
    jtag_addr_load = 0; jtag_xfer = 0; jdo = '0;
    av_address = '0; av_read = 0; av_write = 1; av_writedata = 32'hFFFFFFFF; av_byteenable = 4'hF;

    // reset state, with an Avalon write held against it
    @(negedge clk); #1;
    chk("rst_wait", 32'(av_waitrequest), 32'd1);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_ready", 32'(mon_ready), 32'd0);
    chk("rst_busy", 32'(jtag_busy), 32'd0);
    chk("rst_ovr", 32'(jtag_overrun), 32'd0);
    @(negedge clk);
    av_write = 0; reset = 1'b0;

    // JTAG only: write 0x10, read 0x11, then load+read 0x10
    cyc(); jtag_addr_load = 1; jdo = jdo_addr(8'h10);
    cyc(); jtag_xfer = 1; jdo = jdo_xfer(1'b1, 32'hDEADBEEF);
    cyc(); #1;
    chk("jw_busy", 32'(jtag_busy), 32'd1);
    chk("jw_we", 32'(ram_we), 32'd1);
    chk("jw_addr", 32'(ram_addr), 32'h10);
    chk("jw_data", ram_wdata, 32'hDEADBEEF);
    cyc(); #1;
    chk("jw_ready", 32'(mon_ready), 32'd1);
    chk("jw_mem", mem[8'h10], 32'hDEADBEEF);
    jtag_xfer = 1; jdo = jdo_xfer(1'b0, 32'h0);
    cyc(); #1;
    chk("jr_addr", 32'(ram_addr), 32'h11);
    chk("jr_we", 32'(ram_we), 32'd0);
    cyc(); #1;
    chk("jr_busy_jrd", 32'(jtag_busy), 32'd1);
    chk("jr_noready", 32'(mon_ready), 32'd0);
    cyc(); #1;
    chk("jr_ready", 32'(mon_ready), 32'd1);
    chk("jr_dreg", mon_dreg, 32'h0);
    chk("jr_jaddr", 32'(dut.u_jtag_buf.jtag_addr), 32'h12);
    jtag_addr_load = 1; jtag_xfer = 1; jdo = jdo_addr(8'h10);
    cyc(); #1;
    chk("ld_xfer_addr", 32'(ram_addr), 32'h10);
    cyc();
    cyc(); #1;
    chk("jr2_ready", 32'(mon_ready), 32'd1);
    chk("jr2_dreg", mon_dreg, 32'hDEADBEEF);
    chk("jr2_jaddr", 32'(dut.u_jtag_buf.jtag_addr), 32'h11);

    // Avalon only: partial write, then read with one wait state
    cyc(); av_write = 1; av_address = 8'h20; av_writedata = 32'h12345678; av_byteenable = 4'b0011;
    #1;
    chk("aw_wait", 32'(av_waitrequest), 32'd0);
    chk("aw_we", 32'(ram_we), 32'd1);
    chk("aw_be", 32'(ram_be), 32'h3);
    cyc(); av_write = 0; av_read = 1;
    #1;
    chk("ar_wait1", 32'(av_waitrequest), 32'd1);
    cyc(); #1;
    chk("ar_wait2", 32'(av_waitrequest), 32'd0);
    chk("ar_data", av_readdata, 32'h00005678);
    cyc(); av_read = 0;

    // contention with last_grant = JTAG: Avalon wins first
    cyc(); jtag_addr_load = 1; jdo = jdo_addr(8'h30);
    cyc(); jtag_xfer = 1; jdo = jdo_xfer(1'b1, 32'hA5A5A5A5);
    cyc();
    cyc(); jtag_xfer = 1; jdo = jdo_xfer(1'b0, 32'h0);
    cyc(); av_read = 1; av_address = 8'h40;
    #1;
    chk("c1_gnt_av", 32'(ram_addr), 32'h40);
    chk("c1_wait", 32'(av_waitrequest), 32'd1);
    cyc(); #1;
    chk("c1_wait_ard", 32'(av_waitrequest), 32'd0);
    chk("c1_rdata", av_readdata, 32'h0BADF00D);
    cyc(); av_read = 0;
    #1;
    chk("c1_gnt_j", 32'(ram_addr), 32'h31);
    cyc();
    cyc(); #1;
    chk("c1_ready", 32'(mon_ready), 32'd1);
    chk("c1_dreg", mon_dreg, 32'hCAFEF00D);
    chk("c1_mem30", mem[8'h30], 32'hA5A5A5A5);

    // contention with last_grant = AV: JTAG wins, Avalon stalls 3 cycles
    cyc(); av_write = 1; av_address = 8'h41; av_writedata = 32'h55; av_byteenable = 4'hF;
    cyc(); av_write = 0; jtag_xfer = 1; jdo = jdo_xfer(1'b0, 32'h0);
    cyc(); av_read = 1; av_address = 8'h40;
    #1;
    chk("c2_gnt_j", 32'(ram_addr), 32'h32);
    chk("c2_wait1", 32'(av_waitrequest), 32'd1);
    cyc(); #1;
    chk("c2_wait2", 32'(av_waitrequest), 32'd1);
    cyc(); #1;
    chk("c2_ready", 32'(mon_ready), 32'd1);
    chk("c2_dreg", mon_dreg, 32'h13579BDF);
    chk("c2_gnt_av", 32'(ram_addr), 32'h40);
    chk("c2_wait3", 32'(av_waitrequest), 32'd1);
    cyc(); #1;
    chk("c2_wait4", 32'(av_waitrequest), 32'd0);
    chk("c2_rdata", av_readdata, 32'h0BADF00D);
    chk("c2_mem41", mem[8'h41], 32'h55);
    cyc(); av_read = 0;

    // overrun: back-to-back xfer strobes, second dropped
    we_base = we_cnt;
    cyc(); jtag_xfer = 1; jdo = jdo_xfer(1'b1, 32'h77);
    cyc(); jtag_xfer = 1; jdo = jdo_xfer(1'b1, 32'h88);
    #1;
    chk("ov_busy", 32'(jtag_busy), 32'd1);
    cyc(); #1;
    chk("ov_flag", 32'(jtag_overrun), 32'd1);
    chk("ov_idle_we", 32'(ram_we), 32'd0);
    cyc(); #1;
    chk("ov_we_cnt", 32'(we_cnt - we_base), 32'd1);
    chk("ov_mem33", mem[8'h33], 32'h77);
    chk("ov_mem34", mem[8'h34], 32'h0);
    chk("ov_sticky", 32'(jtag_overrun), 32'd1);

    // address wrap
    cyc(); jtag_addr_load = 1; jdo = jdo_addr(8'hFF);
    cyc(); jtag_xfer = 1; jdo = jdo_xfer(1'b1, 32'h1);
    cyc(); #1;
    chk("wr_addr_ff", 32'(ram_addr), 32'hFF);
    cyc(); jtag_xfer = 1; jdo = jdo_xfer(1'b1, 32'h2);
    cyc(); #1;
    chk("wr_addr_00", 32'(ram_addr), 32'h00);
    chk("wr_we", 32'(ram_we), 32'd1);
    cyc(); #1;
    chk("wr_mem_ff", mem[8'hFF], 32'h1);
    chk("wr_mem_00", mem[8'h00], 32'h2);
    chk("wr_jaddr", 32'(dut.u_jtag_buf.jtag_addr), 32'h01);

    // reset during J_RD
    cyc(); jtag_addr_load = 1; jtag_xfer = 1; jdo = jdo_addr(8'h50);
    cyc();
    cyc(); #1;
    chk("rj_busy", 32'(jtag_busy), 32'd1);
    reset = 1; av_read = 1; av_address = 8'h20;
    #1;
    chk("rj_wait", 32'(av_waitrequest), 32'd1);
    chk("rj_pend", 32'(dut.u_jtag_buf.pend_valid), 32'd0);
    chk("rj_jaddr", 32'(dut.u_jtag_buf.jtag_addr), 32'h0);
    chk("rj_ovr", 32'(jtag_overrun), 32'd0);
    chk("rj_busy0", 32'(jtag_busy), 32'd0);
    cyc(); #1;
    chk("rj_noready", 32'(mon_ready), 32'd0);
    chk("rj_we", 32'(ram_we), 32'd0);
    reset = 0;
    #1;
    chk("rs_wait1", 32'(av_waitrequest), 32'd1);
    cyc(); #1;
    chk("rs_wait2", 32'(av_waitrequest), 32'd0);
    chk("rs_rdata", av_readdata, 32'h00005678);
    cyc(); av_read = 0; jtag_addr_load = 1; jtag_xfer = 1; jdo = jdo_addr(8'h50);
    #1;
    chk("rs_noready", 32'(mon_ready), 32'd0);
    cyc();
    cyc();
    cyc(); #1;
    chk("rs_ready", 32'(mon_ready), 32'd1);
    chk("rs_dreg", mon_dreg, 32'h600DCAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
